muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the forwarded ALU operands (outputs of the EX-stage operand forwarding muxes) for M-extension instructions.
- Raises a stall request that freezes IF/ID/EX while an operation runs.
- Presents the 32-bit result alongside the ALU result for the EX/MEM register.

Parameters:
WORD_LEN, 32, operand/result width (matches `WORD_LEN`)
CNT_WIDTH, 6, iteration counter width (holds 0..WORD_LEN)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  EX holds a valid M-extension instruction (held high by the pipeline while stalled)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opA  input  WORD_LEN  forwarded rs1 value
opB  input  WORD_LEN  forwarded rs2 value
flush  input  1  synchronous abort (branch/exception flush of EX)
stall  output  1  pipeline freeze request
valid  output  1  result valid this cycle
result  output  WORD_LEN  operation result

Behaviour:

Reset:
- rst_n low, asynchronously: state=IDLE, counter=0, internal accumulators=0, result=0, valid=0, stall=0.
- Reset takes effect mid-operation with no partial result escaping.

States: IDLE, CALC, DONE.

IDLE:
- start=1 and flush=0 at an edge: latch op, sign flags, and |opA|/|opB|.
  - Absolute values apply only for operands treated as signed: MULH both; MULHSU A only; DIV/REM both.
- Normal operations then enter CALC with counter=0.
- Fast-path cases skip CALC and go straight to DONE with the result registered:
  - divide by zero (opB=0): DIV/DIVU → 0xFFFFFFFF; REM/REMU → opA.
  - signed overflow (DIV/REM, opA=0x80000000, opB=0xFFFFFFFF): DIV → 0x80000000; REM → 0.

CALC:
- One radix-2 iteration per edge, counter+1.
  - multiply: shift-add into a 64-bit product.
  - divide: restoring shift-subtract producing quotient and remainder.
- The edge where counter reaches WORD_LEN (32 iterations) moves to DONE.
- On that edge the result is registered after sign correction:
  - MUL: low 32 bits of the product.
  - MULH*: high 32 bits, product negated if the signs differ.
  - DIV: quotient negated if the signs differ.
  - REM: remainder takes the sign of the dividend.

DONE:
- valid=1 and stall=0 for exactly one cycle, so the pipeline advances.
- start is ignored in DONE (it belongs to the completing instruction).
- Next edge: IDLE.

stall (combinational):
- stall = (state==IDLE && start && !flush) || state==CALC.
- Normal op: stall high for 33 cycles, valid on the 34th.
- Fast path: stall high for 1 cycle, valid on the 2nd.

result:
- Registered; holds its last value outside DONE.
- Consumers qualify it with valid.

flush:
- Sampled at the edge.
- In CALC or DONE: next state IDLE, counter=0, valid=0.
- result is not updated by an aborted operation.
- flush in IDLE suppresses start.

Widths:
- All arithmetic is internal two's complement.
- Intermediate product is 2×WORD_LEN.
- Divider remainder register is WORD_LEN+1 bits for the borrow.
- No X-propagation on undefined op codes: all 8 codes are defined.

Back-to-back:
- A new start is accepted the cycle after DONE (in IDLE); the minimum gap is 0 idle cycles.

Test Plan:
1. MUL opA=7, opB=0xFFFFFFFD (−3) → stall 33 cycles, then valid=1 for one cycle, result=0xFFFFFFEB; MULHU opA=opB=0xFFFFFFFF → result=0xFFFFFFFE.
2. DIV opA=0xFFFFFFF9 (−7), opB=2 → result=0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
3. DIV and REMU with opB=0, opA=0x1234 → stall 1 cycle; results 0xFFFFFFFF and 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
4. MULHSU opA=0xFFFFFFFF (−1), opB=2 → result=0xFFFFFFFF; MULH 0x80000000×0x80000000 → 0x40000000.
5. Start DIVU, assert flush at CALC cycle 10 → stall drops the next cycle, valid never rises, result keeps its previous value; an immediate new MUL 3×4 → 12.
6. Drop rst_n mid-CALC (between edges) → stall, valid, result=0 immediately; after release, start MUL 5×5 → 25 after the normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit for the EX stage.
//                Radix-2 shift-add multiply and restoring divide, with
//                single-cycle fast paths for divide-by-zero and signed
//                overflow. Requests a pipeline stall while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WORD_LEN  = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WORD_LEN-1:0] opA,
  input  logic [WORD_LEN-1:0] opB,
  input  logic                flush,
  output logic                stall,
  output logic                valid,
  output logic [WORD_LEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_LEN - 1);
  localparam logic [WORD_LEN-1:0]  MOST_NEG  = {1'b1, {(WORD_LEN-1){1'b0}}};

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_q, neg_d;          // final result must be negated
  logic [WORD_LEN-1:0]   opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [2*WORD_LEN-1:0] prod_q, prod_d;        // {partial product, multiplier}
  logic [WORD_LEN:0]     rem_q, rem_d;          // partial remainder (extra bit for borrow)
  logic [WORD_LEN-1:0]   quo_q, quo_d;          // dividend shifting out, quotient shifting in
  logic [WORD_LEN-1:0]   result_q, result_d;
  logic                  valid_q, valid_d;

  logic                  signed_a, signed_b, a_neg, b_neg;
  logic [WORD_LEN-1:0]   abs_a, abs_b;
  logic                  div_zero, div_ovf;
  logic [WORD_LEN:0]     mul_sum;
  logic [2*WORD_LEN-1:0] prod_step, prod_fin;
  logic [WORD_LEN+1:0]   div_diff;
  logic [WORD_LEN:0]     rem_step;
  logic [WORD_LEN-1:0]   quo_step, quo_fin, rem_fin, fin_res;

  // Operand decode, one datapath iteration and the sign-corrected final result
  always_comb begin
    signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = signed_a && opA[WORD_LEN-1];
    b_neg    = signed_b && opB[WORD_LEN-1];
    abs_a    = a_neg ? -opA : opA;
    abs_b    = b_neg ? -opB : opB;
    div_zero = op[2] && (opB == '0);
    div_ovf  = op[2] && !op[0] && (opA == MOST_NEG) && (opB == '1);

    // Shift-add: conditionally add multiplicand to the upper half, shift right.
    mul_sum   = {1'b0, prod_q[2*WORD_LEN-1:WORD_LEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    prod_step = {mul_sum, prod_q[WORD_LEN-1:1]};

    // Restoring divide: shift in next dividend bit, keep the difference if no borrow.
    div_diff = {rem_q, quo_q[WORD_LEN-1]} - {2'b00, opnd_q};
    if (div_diff[WORD_LEN+1]) begin
      rem_step = {rem_q[WORD_LEN-1:0], quo_q[WORD_LEN-1]};
      quo_step = {quo_q[WORD_LEN-2:0], 1'b0};
    end else begin
      rem_step = div_diff[WORD_LEN:0];
      quo_step = {quo_q[WORD_LEN-2:0], 1'b1};
    end

    // MUL never sets neg_q, so prod_fin also serves as the plain low product.
    prod_fin = neg_q ? -prod_step : prod_step;
    quo_fin  = neg_q ? -quo_step : quo_step;
    rem_fin  = neg_q ? -rem_step[WORD_LEN-1:0] : rem_step[WORD_LEN-1:0];

    case (op_q)
      OP_MUL:                       fin_res = prod_fin[WORD_LEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fin[2*WORD_LEN-1:WORD_LEN];
      OP_DIV, OP_DIVU:              fin_res = quo_fin;
      OP_REM, OP_REMU:              fin_res = rem_fin;
      default:                      fin_res = prod_fin[WORD_LEN-1:0];
    endcase
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequencer and its datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = op;
          cnt_d = '0;
          // Remainder follows the dividend; everything else follows sign(A)^sign(B).
          neg_d = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            result_d = op[1] ? opA : '1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = op[1] ? '0 : MOST_NEG;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            opnd_d  = op[2] ? abs_b : abs_a;
            prod_d  = {{WORD_LEN{1'b0}}, abs_b};
            rem_d   = '0;
            quo_d   = abs_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (op_q[2]) begin
            rem_d = rem_step;
            quo_d = quo_step;
          end else begin
            prod_d = prod_step;
          end
          if (cnt_q == LAST_ITER) begin
            result_d = fin_res;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        // start here still belongs to the completing instruction
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
  assign valid  = valid_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit with a result queue
//                and an independent RV32M reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall;
  logic        valid;
  logic [31:0] result;

  int checks;
  int failures;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  muldiv_unit #(.WORD_LEN(32), .CNT_WIDTH(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .opA    (opa),
    .opB    (opb),
    .flush  (flush),
    .stall  (stall),
    .valid  (valid),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M reference semantics
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    logic signed [31:0] x, y, q;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'h0, b};
    x = a;
    y = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = x / y; return q;
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        q = x % y; return q;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Drive one instruction, hold start while stalled, return the valid-cycle result
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stalls, output bit done);
    stalls = 0;
    done   = 1'b0;
    res    = '0;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (valid === 1'b1) begin
        done = 1'b1;
        res  = result;
        break;
      end
      if (stall === 1'b1) stalls++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    vec_t v[4];
    logic [31:0] res, exp;
    int st;
    bit done;
    v[0] = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    v[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    v[2] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    v[3] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    foreach (v[i]) begin
      sb_q.push_back(v[i].exp);
      run_op(v[i].op, v[i].a, v[i].b, res, st, done);
      exp = sb_q.pop_front();
      checks++;
      if (!done || res !== exp) begin failures++; $display("FAIL mul%0d result got=%h want=%h done=%0d", i, res, exp, done); end
      checks++;
      if (st != v[i].stalls) begin failures++; $display("FAIL mul%0d stall_cycles got=%0d want=%0d", i, st, v[i].stalls); end
      @(negedge clk); #1;
      checks++;
      if (valid !== 1'b0) begin failures++; $display("FAIL mul%0d valid_pulse got=%b want=0", i, valid); end
    end
  endtask

  task automatic test_div();
    vec_t v[4];
    logic [31:0] res, exp;
    int st;
    bit done;
    v[0] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    v[1] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    v[2] = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
    v[3] = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
    foreach (v[i]) begin
      sb_q.push_back(v[i].exp);
      run_op(v[i].op, v[i].a, v[i].b, res, st, done);
      exp = sb_q.pop_front();
      checks++;
      if (!done || res !== exp) begin failures++; $display("FAIL div%0d result got=%h want=%h done=%0d", i, res, exp, done); end
      checks++;
      if (st != v[i].stalls) begin failures++; $display("FAIL div%0d stall_cycles got=%0d want=%0d", i, st, v[i].stalls); end
    end
  endtask

  task automatic test_fastpath();
    vec_t v[4];
    logic [31:0] res, exp;
    int st;
    bit done;
    v[0] = '{3'd4, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1};
    v[1] = '{3'd7, 32'h0000_1234, 32'h0, 32'h0000_1234, 1};
    v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};
    foreach (v[i]) begin
      sb_q.push_back(v[i].exp);
      run_op(v[i].op, v[i].a, v[i].b, res, st, done);
      exp = sb_q.pop_front();
      checks++;
      if (!done || res !== exp) begin failures++; $display("FAIL fast%0d result got=%h want=%h done=%0d", i, res, exp, done); end
      checks++;
      if (st != v[i].stalls) begin failures++; $display("FAIL fast%0d stall_cycles got=%0d want=%0d", i, st, v[i].stalls); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, exp;
    int st, vseen;
    bit done;
    // flush in IDLE suppresses start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; opa = 32'd100; opb = 32'd7;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_idle_stall got=%b want=0", stall); end
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL flush_idle_state stall=%b valid=%b want=0/0", stall, valid); end
    start = 1'b0; flush = 1'b0;
    // establish a known held result
    sb_q.push_back(32'h0000_3333);
    run_op(3'd0, 32'h0000_1111, 32'd3, res, st, done);
    exp = sb_q.pop_front();
    checks++;
    if (!done || res !== exp) begin failures++; $display("FAIL flush_pre result got=%h want=%h", res, exp); end
    // DIVU aborted at CALC cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd5; opa = 32'hFFFF_0000; opb = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL flush_calc_stall got=%b want=1", stall); end
    flush = 1'b1; start = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall_drop got=%b want=0", stall); end
    flush = 1'b0;
    vseen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid === 1'b1) vseen++;
      @(negedge clk); #1;
    end
    checks++;
    if (vseen != 0) begin failures++; $display("FAIL flush_valid got=%0d want=0", vseen); end
    checks++;
    if (result !== exp) begin failures++; $display("FAIL flush_result_held got=%h want=%h", result, exp); end
    // immediate new MUL
    sb_q.push_back(32'd12);
    run_op(3'd0, 32'd3, 32'd4, res, st, done);
    exp = sb_q.pop_front();
    checks++;
    if (!done || res !== exp || st != 33) begin failures++; $display("FAIL flush_post result got=%h want=%h stalls=%0d", res, exp, st); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res, exp;
    int st;
    bit done;
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'd9; opb = 32'd9;
    repeat (5) @(negedge clk);
    #2;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL arst_ctrl stall=%b valid=%b want=0/0", stall, valid); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL arst_result got=%h want=00000000", result); end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(32'd25);
    run_op(3'd0, 32'd5, 32'd5, res, st, done);
    exp = sb_q.pop_front();
    checks++;
    if (!done || res !== exp) begin failures++; $display("FAIL arst_post result got=%h want=%h", res, exp); end
    checks++;
    if (st != 33) begin failures++; $display("FAIL arst_post stall_cycles got=%0d want=33", st); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, exp, a, b;
    logic [2:0]  o;
    int st, est;
    bit done;
    for (int i = 0; i < 14; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) b = 32'h0;
      if (i % 7 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      est = (o[2] && (b == 32'h0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
      sb_q.push_back(ref_model(o, a, b));
      run_op(o, a, b, res, st, done);
      exp = sb_q.pop_front();
      checks++;
      if (!done || res !== exp) begin failures++; $display("FAIL b2b%0d op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, res, exp); end
      checks++;
      if (st != est) begin failures++; $display("FAIL b2b%0d stall_cycles got=%0d want=%0d", i, st, est); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; start = 1'b0; flush = 1'b0;
    op = 3'd0; opa = 32'h0; opb = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_fastpath();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
